// File: rtl/ws2812_pkg.sv
// Shared types, timing helpers and channel scaling for the WS2812 stream driver.
package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } state_t;

  localparam int unsigned DEF_CLK_HZ    = 50_000_000;
  localparam int unsigned DEF_T0H_NS    = 400;
  localparam int unsigned DEF_T1H_NS    = 800;
  localparam int unsigned DEF_TBIT_NS   = 1250;
  localparam int unsigned DEF_TLATCH_NS = 50_000;

  // Floor conversion; the clock is pre-divided to kHz so 64-bit math never overflows.
  function automatic longint unsigned ns_to_cycles(input longint unsigned clk_hz,
                                                   input longint unsigned ns);
    return (clk_hz / 1000) * ns / 1000000;
  endfunction

  function automatic logic [7:0] scale8(input logic [7:0] ch, input logic [7:0] level);
    return 8'((16'(ch) * 16'({1'b0, level} + 9'd1)) >> 8);
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Generates one NRZ bit (high phase then low phase) per accepted go; owns the data register.
module ws2812_bit_encoder #(
  parameter int unsigned T0H   = 20,
  parameter int unsigned T1H   = 40,
  parameter int unsigned TBIT  = 62,
  parameter int unsigned CNT_W = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic bit_val,
  output logic data,
  output logic active,
  output logic high,
  output logic done
);

  logic [CNT_W-1:0] cnt;
  logic             cur_bit;

  // Last cycle of the low phase: a go seen here starts the next bit with no gap.
  assign done = active && !high && (cnt == '0);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data    <= 1'b0;
      active  <= 1'b0;
      high    <= 1'b0;
      cur_bit <= 1'b0;
      cnt     <= '0;
    end else if (go && (!active || done)) begin
      data    <= 1'b1;
      active  <= 1'b1;
      high    <= 1'b1;
      cur_bit <= bit_val;
      cnt     <= bit_val ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
    end else if (active) begin
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else if (high) begin
        data <= 1'b0;
        high <= 1'b0;
        cnt  <= cur_bit ? CNT_W'(TBIT - T1H - 1) : CNT_W'(TBIT - T0H - 1);
      end else begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ws2812_stream_tx.sv
// WS2812/SK6812 frame sender fed by a valid/ready pixel stream.
// Define WS2812_BRIGHTNESS_EN to add a global per-channel brightness input.
module ws2812_stream_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned NUM_PIXELS     = 16,
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned T0H_NS         = DEF_T0H_NS,
  parameter int unsigned T1H_NS         = DEF_T1H_NS,
  parameter int unsigned TBIT_NS        = DEF_TBIT_NS,
  parameter int unsigned TLATCH_NS      = DEF_TLATCH_NS
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET_N,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]                brightness,
`endif
  input  logic                      start,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      underrun,
  output logic                      data
);

  localparam int unsigned T0H     = 32'(ns_to_cycles(CLK_HZ, T0H_NS));
  localparam int unsigned T1H     = 32'(ns_to_cycles(CLK_HZ, T1H_NS));
  localparam int unsigned TBIT    = 32'(ns_to_cycles(CLK_HZ, TBIT_NS));
  localparam int unsigned TLATCH  = 32'(ns_to_cycles(CLK_HZ, TLATCH_NS));
  localparam int unsigned CNT_MAX = (TBIT > TLATCH) ? TBIT : TLATCH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PIX_W   = $clog2(NUM_PIXELS + 1);
  localparam int unsigned BIT_W   = $clog2(BITS_PER_PIXEL);

  state_t                    state, state_next;
  logic [BITS_PER_PIXEL-1:0] buf_q, load_word, shift_q;
  logic                      buf_full;
  logic [PIX_W-1:0]          pix_cnt;
  logic [BIT_W-1:0]          bit_idx;
  logic [CNT_W-1:0]          lcnt;
  logic                      enc_go, enc_bit, enc_active, enc_high, enc_done;
  logic                      last_bit;

`ifdef WS2812_BRIGHTNESS_EN
  always_comb begin
    load_word = buf_q;
    for (int c = 0; c < BITS_PER_PIXEL / 8; c++)
      load_word[c*8 +: 8] = scale8(buf_q[c*8 +: 8], brightness);
  end
`else
  assign load_word = buf_q;
`endif

  assign pix_ready = !buf_full;
  assign busy      = (state != IDLE);
  assign last_bit  = (bit_idx == BIT_W'(BITS_PER_PIXEL - 1));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    enc_go     = 1'b0;
    enc_bit    = shift_q[BITS_PER_PIXEL-1];
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        if (buf_full) begin
          state_next = HIGH;
          // Later pixels start their first bit straight from LOAD to keep the gap to one cycle.
          if (pix_cnt != '0) begin
            enc_go  = 1'b1;
            enc_bit = load_word[BITS_PER_PIXEL-1];
          end
        end else if (pix_cnt != '0) begin
          state_next = LATCH;
        end
      end
      HIGH: begin
        enc_go = !enc_active;
        if (enc_active && !enc_high) state_next = LOW;
      end
      LOW: begin
        if (enc_done) begin
          if (last_bit) begin
            state_next = (pix_cnt == PIX_W'(NUM_PIXELS - 1)) ? LATCH : LOAD;
          end else begin
            enc_go     = 1'b1;
            enc_bit    = shift_q[BITS_PER_PIXEL-2];
            state_next = HIGH;
          end
        end
      end
      LATCH:   if (lcnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the pixel buffer is reset too, so a reset discards a half-delivered word.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state      <= IDLE;
      buf_q      <= '0;
      buf_full   <= 1'b0;
      shift_q    <= '0;
      bit_idx    <= '0;
      pix_cnt    <= '0;
      lcnt       <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= (state == LATCH) && (lcnt == '0);
      underrun   <= (state == LOAD) && !buf_full && (pix_cnt != '0);

      if (pix_valid && !buf_full) begin
        buf_q    <= pix_data;
        buf_full <= 1'b1;
      end
      if (state == LOAD && buf_full) begin
        buf_full <= 1'b0;
        shift_q  <= load_word;
        bit_idx  <= '0;
      end
      if (state == LOW && enc_done) begin
        if (last_bit) begin
          pix_cnt <= pix_cnt + PIX_W'(1);
        end else begin
          shift_q <= shift_q << 1;
          bit_idx <= bit_idx + BIT_W'(1);
        end
      end
      if (state == IDLE && start) pix_cnt <= '0;

      if (state_next == LATCH && state != LATCH) lcnt <= CNT_W'(TLATCH - 1);
      else if (lcnt != '0)                       lcnt <= lcnt - CNT_W'(1);
    end
  end

  ws2812_bit_encoder #(
    .T0H   (T0H),
    .T1H   (T1H),
    .TBIT  (TBIT),
    .CNT_W (CNT_W)
  ) u_enc (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .go      (enc_go),
    .bit_val (enc_bit),
    .data    (data),
    .active  (enc_active),
    .high    (enc_high),
    .done    (enc_done)
  );

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Bench for ws2812_stream_tx: records serial-line edges and compares them with
// a word/bit-level model of a frame (pulse widths, periods, latch, handshake).
`timescale 1ns/1ps
module tb_ws2812_stream_tx;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned NP     = 3;
  localparam int unsigned BPP    = 24;
  localparam longint      KHZ    = longint'(CLK_HZ) / 1000;
  localparam int T0H    = int'(KHZ * 400 / 1000000);
  localparam int T1H    = int'(KHZ * 800 / 1000000);
  localparam int TBIT   = int'(KHZ * 1250 / 1000000);
  localparam int TLATCH = int'(KHZ * 50000 / 1000000);
  localparam int BUDGET = int'(NP * BPP) * (TBIT + 2) + TLATCH + 100;

  typedef logic [BPP-1:0] wordq_t[$];
  typedef bit             bitq_t[$];

  logic           CLOCK_50  = 1'b0;
  logic           RESET_N   = 1'b0;
  logic           start     = 1'b0;
  logic           pix_valid = 1'b0;
  logic [BPP-1:0] pix_data  = '0;
  logic           pix_ready, busy, frame_done, underrun, data;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]     brightness = 8'd255;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise_q[$], fall_q[$], done_q[$], und_q[$], start_q[$];
  logic [1:0] done_busy_q[$];
  logic data_prev = 1'b0;
  logic busy_prev = 1'b0;

  ws2812_stream_tx #(
    .CLK_HZ         (CLK_HZ),
    .NUM_PIXELS     (NP),
    .BITS_PER_PIXEL (BPP)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .start      (start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun),
    .data       (data)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Inputs are stable at the active edge; outputs are sampled half a cycle later.
  always @(posedge CLOCK_50) begin
    cyc++;
    if (start && RESET_N) start_q.push_back(cyc);
  end

  always @(negedge CLOCK_50) begin
    if (data && !data_prev) rise_q.push_back(cyc);
    if (!data && data_prev) fall_q.push_back(cyc);
    if (frame_done) begin
      done_q.push_back(cyc);
      done_busy_q.push_back({busy_prev, busy});
    end
    if (underrun) und_q.push_back(cyc);
    data_prev = data;
    busy_prev = busy;
  end

  task automatic clear_mon();
    rise_q.delete(); fall_q.delete(); done_q.delete();
    und_q.delete(); start_q.delete(); done_busy_q.delete();
  endtask

  task automatic push_word(input logic [BPP-1:0] w, output bit ok);
    int n = 0;
    pix_data  = w;
    pix_valid = 1'b1;
    while (!pix_ready && n < BUDGET) begin
      @(negedge CLOCK_50);
      n++;
    end
    ok = pix_ready;
    @(negedge CLOCK_50);
    pix_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic send_frame(input wordq_t w, input int n_supply, output int misses);
    bit ok;
    misses = 0;
    push_word(w[0], ok);
    if (!ok) misses++;
    pulse_start();
    for (int i = 1; i < n_supply; i++) begin
      push_word(w[i], ok);
      if (!ok) misses++;
    end
  endtask

  task automatic wait_done(output bit got);
    for (int k = 0; k < BUDGET && done_q.size() == 0; k++) @(negedge CLOCK_50);
    got = (done_q.size() != 0);
    repeat (20) @(negedge CLOCK_50);
  endtask

  function automatic bitq_t bits_of(input wordq_t w);
    bitq_t b;
    foreach (w[i])
      for (int k = BPP - 1; k >= 0; k--) b.push_back(w[i][k]);
    return b;
  endfunction

  function automatic wordq_t decode_words();
    wordq_t   out;
    logic [BPP-1:0] acc = '0;
    for (int i = 0; i < fall_q.size() && i < rise_q.size(); i++) begin
      acc = {acc[BPP-2:0], ((fall_q[i] - rise_q[i]) > (T0H + T1H) / 2)};
      if (i % BPP == BPP - 1) out.push_back(acc);
    end
    return out;
  endfunction

  function automatic logic [BPP-1:0] dim(input logic [BPP-1:0] w, input int lvl);
    logic [BPP-1:0] r;
    for (int c = 0; c < BPP / 8; c++)
      r[c*8 +: 8] = 8'((int'(w[c*8 +: 8]) * (lvl + 1)) >> 8);
    return r;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge CLOCK_50);
    total++; if (data !== 1'b0)       begin bad++; $display("FAIL reset_data got=%b want=0", data); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
    total++; if (underrun !== 1'b0)   begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    total++; if (pix_ready !== 1'b1)  begin bad++; $display("FAIL reset_ready got=%b want=1", pix_ready); end
    RESET_N = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    total++; if (busy !== 1'b0 || pix_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_idle busy=%b ready=%b want 0/1", busy, pix_ready);
    end
  endtask

  task automatic test_frame(input string name, input wordq_t words, input wordq_t exp);
    int    misses, per, hi_last;
    bit    got, boundary;
    bitq_t eb;
    clear_mon();
    send_frame(words, NP, misses);
    wait_done(got);
    eb = bits_of(exp);
    total++; if (misses != 0 || !got) begin
      bad++; $display("FAIL %s_timeout misses=%0d done_seen=%0d want 0/1", name, misses, got);
    end
    total++; if (rise_q.size() != eb.size() || fall_q.size() != eb.size()) begin
      bad++; $display("FAIL %s_nbits got=%0d/%0d want=%0d", name, rise_q.size(), fall_q.size(), eb.size());
    end else begin
      foreach (eb[i]) begin
        total++; if (fall_q[i] - rise_q[i] != (eb[i] ? T1H : T0H)) begin
          bad++; $display("FAIL %s_high[%0d] got=%0d want=%0d", name, i, fall_q[i] - rise_q[i], eb[i] ? T1H : T0H);
        end
      end
      for (int i = 1; i < eb.size(); i++) begin
        per      = rise_q[i] - rise_q[i-1];
        boundary = (i % BPP == 0);
        total++; if (boundary ? (per < TBIT - 1 || per > TBIT + 1) : (per != TBIT)) begin
          bad++; $display("FAIL %s_period[%0d] got=%0d want=%0d%s", name, i, per, TBIT, boundary ? "+-1" : "");
        end
      end
      hi_last = eb[eb.size()-1] ? T1H : T0H;
      total++; if (done_q.size() == 0 || done_q[0] - fall_q[fall_q.size()-1] != TBIT - hi_last + TLATCH) begin
        bad++; $display("FAIL %s_latch got=%0d want=%0d", name,
                        (done_q.size() == 0) ? -1 : done_q[0] - fall_q[fall_q.size()-1], TBIT - hi_last + TLATCH);
      end
    end
    total++; if (rise_q.size() == 0 || start_q.size() == 0 || rise_q[0] - start_q[0] != 2) begin
      bad++; $display("FAIL %s_latency got=%0d want=2", name,
                      (rise_q.size() == 0 || start_q.size() == 0) ? -1 : rise_q[0] - start_q[0]);
    end
    total++; if (done_q.size() != 1) begin
      bad++; $display("FAIL %s_done_count got=%0d want=1", name, done_q.size());
    end
    total++; if (done_busy_q.size() == 0 || done_busy_q[0] !== 2'b10) begin
      bad++; $display("FAIL %s_busy_fall got=%b want=10", name, (done_busy_q.size() == 0) ? 2'bxx : done_busy_q[0]);
    end
  endtask

  task automatic test_underrun();
    wordq_t w;
    int     misses, gap;
    bit     got;
    clear_mon();
    w.push_back(BPP'($urandom));
    send_frame(w, 1, misses);
    wait_done(got);
    gap = TBIT - (w[0][0] ? T1H : T0H) + 1;
    total++; if (misses != 0 || !got) begin
      bad++; $display("FAIL under_timeout misses=%0d done_seen=%0d want 0/1", misses, got);
    end
    total++; if (decode_words().size() != 1 || decode_words()[0] !== w[0] || rise_q.size() != BPP) begin
      bad++; $display("FAIL under_word bits=%0d want=%0d sent=%h", rise_q.size(), BPP, w[0]);
    end
    total++; if (und_q.size() != 1) begin
      bad++; $display("FAIL under_count got=%0d want=1", und_q.size());
    end else if (fall_q.size() == BPP) begin
      total++; if (und_q[0] - fall_q[BPP-1] != gap) begin
        bad++; $display("FAIL under_time got=%0d want=%0d", und_q[0] - fall_q[BPP-1], gap);
      end
    end
    total++; if (done_q.size() != 1) begin
      bad++; $display("FAIL under_done_count got=%0d want=1", done_q.size());
    end else if (fall_q.size() == BPP) begin
      total++; if (done_q[0] - fall_q[BPP-1] != gap + TLATCH) begin
        bad++; $display("FAIL under_latch got=%0d want=%0d", done_q[0] - fall_q[BPP-1], gap + TLATCH);
      end
    end
  endtask

  task automatic test_busy_ignore();
    wordq_t w, dec;
    bit     ok0, ok1, got;
    int     viol = 0;
    int     n    = 0;
    clear_mon();
    repeat (NP) w.push_back(BPP'($urandom));
    push_word(w[0], ok0);
    pulse_start();
    push_word(w[1], ok1);
    pix_data  = w[2];
    pix_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      start = (i == 50);
      if (pix_ready !== 1'b0) viol++;
      @(negedge CLOCK_50);
    end
    start = 1'b0;
    total++; if (viol != 0) begin
      bad++; $display("FAIL busy_ready_held got=%0d ready cycles want=0", viol);
    end
    while (!pix_ready && n < BUDGET) begin
      @(negedge CLOCK_50);
      n++;
    end
    total++; if (!(ok0 && ok1 && pix_ready)) begin
      bad++; $display("FAIL busy_handshake got=%b%b%b want=111", ok0, ok1, pix_ready);
    end
    @(negedge CLOCK_50);
    pix_valid = 1'b0;
    wait_done(got);
    dec = decode_words();
    total++; if (dec.size() != NP) begin
      bad++; $display("FAIL busy_nwords got=%0d want=%0d", dec.size(), NP);
    end else begin
      foreach (w[i]) begin
        total++; if (dec[i] !== w[i]) begin
          bad++; $display("FAIL busy_word[%0d] got=%h want=%h", i, dec[i], w[i]);
        end
      end
    end
    total++; if (!got || done_q.size() != 1) begin
      bad++; $display("FAIL busy_done_count got=%0d want=1", done_q.size());
    end
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL busy_restart got=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok0, ok1;
    int n = 0;
    clear_mon();
    push_word(BPP'($urandom), ok0);
    pulse_start();
    push_word(BPP'($urandom), ok1);
    while (!data && n < BUDGET) begin
      @(negedge CLOCK_50);
      n++;
    end
    repeat (5) @(negedge CLOCK_50);
    total++; if (data !== 1'b1 || !ok0 || !ok1) begin
      bad++; $display("FAIL rmid_pre got data=%b ok=%b%b want 1/11", data, ok0, ok1);
    end
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    total++; if (data !== 1'b0)      begin bad++; $display("FAIL rmid_data got=%b want=0", data); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", pix_ready); end
    RESET_N = 1'b1;
    clear_mon();
    repeat (2 * TLATCH) @(negedge CLOCK_50);
    total++; if (done_q.size() != 0 || rise_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_quiet got done=%0d rises=%0d busy=%b want 0/0/0", done_q.size(), rise_q.size(), busy);
    end
  endtask

`ifdef WS2812_BRIGHTNESS_EN
  task automatic test_brightness();
    wordq_t w, e;
    int     lvl;
    brightness = 8'd127;
    repeat (NP) begin
      w.push_back(24'hFF8040);
      e.push_back(24'h7F4020);
    end
    test_frame("bright127", w, e);
    w.delete(); e.delete();
    lvl        = int'($urandom_range(0, 255));
    brightness = 8'(lvl);
    repeat (NP) w.push_back(BPP'($urandom));
    foreach (w[i]) e.push_back(dim(w[i], lvl));
    test_frame("bright_rand", w, e);
    brightness = 8'd255;
  endtask
`endif

  initial begin
    wordq_t w;
    test_reset();
    w = {24'hFF0000, 24'h00000F, 24'h800001};
    test_frame("fixed", w, w);
    repeat (2) begin
      w.delete();
      repeat (NP) w.push_back(BPP'($urandom));
      test_frame("random", w, w);
    end
    test_underrun();
    test_busy_ignore();
    test_reset_mid();
`ifdef WS2812_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
